mem_port_arbiter: RTL and testbench

- Shares one single-ported unified 16-bit memory between the instruction-fetch stage (read-only) and the memory-access stage (read/write).
- Sequences each access through a fixed-latency memory protocol and returns read data.
- Drives stall signals to the pipeline while a requester waits.
- Data port has priority, with a starvation guard for fetch.

---
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency single-ported memory between instruction
// fetch and the data port, favouring data but guaranteeing fetch a turn after STARVE_MAX losses.
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [2:0] LAT_LOAD   = 3'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t            state, state_next;
    logic              owner, owner_next;
    logic [ADDR_W-1:0] addr_q, addr_next;
    logic              we_q, we_next;
    logic [DATA_W-1:0] wdata_q, wdata_next;
    logic [2:0]        lat_cnt, lat_next;
    logic [3:0]        starve_cnt, starve_next;
    logic [DATA_W-1:0] if_rdata_next, d_rdata_next;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            state      <= state_next;
            owner      <= owner_next;
            addr_q     <= addr_next;
            we_q       <= we_next;
            wdata_q    <= wdata_next;
            lat_cnt    <= lat_next;
            starve_cnt <= starve_next;
            if_rdata   <= if_rdata_next;
            d_rdata    <= d_rdata_next;
        end
    end

    always_comb begin
        state_next    = state;
        owner_next    = owner;
        addr_next     = addr_q;
        we_next       = we_q;
        wdata_next    = wdata_q;
        lat_next      = lat_cnt;
        starve_next   = starve_cnt;
        if_rdata_next = if_rdata;
        d_rdata_next  = d_rdata;
        case (state)
            IDLE: begin
                // Data wins unless fetch has already lost STARVE_MAX times in a row
                if (d_req && !(if_req && starve_cnt == STARVE_LIM)) begin
                    owner_next = 1'b1;
                    addr_next  = d_addr;
                    we_next    = d_we;
                    wdata_next = d_wdata;
                    state_next = ISSUE;
                    if (if_req && starve_cnt != 4'hF) begin
                        starve_next = starve_cnt + 4'd1;
                    end
                end else if (if_req) begin
                    owner_next  = 1'b0;
                    addr_next   = if_addr;
                    we_next     = 1'b0;
                    wdata_next  = '0;
                    starve_next = '0;
                    state_next  = ISSUE;
                end
            end
            ISSUE: begin
                lat_next   = LAT_LOAD;
                state_next = WAIT;
            end
            WAIT: begin
                if (lat_cnt == 3'd0) begin
                    if (!we_q) begin
                        if (owner) begin
                            d_rdata_next = mem_rdata;
                        end else begin
                            if_rdata_next = mem_rdata;
                        end
                    end
                    state_next = DONE;
                end else begin
                    lat_next = lat_cnt - 3'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Strobes decode straight from the async-reset state so they fall the instant Rst asserts
    assign mem_en    = (state == ISSUE);
    assign mem_we    = (state == ISSUE) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_valid  = (state == DONE) && !owner;
    assign d_valid   = (state == DONE) && owner;
    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = d_req & ~d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed timing checks plus randomized two-port traffic, scored by
// a queue-based model against a fixed-latency memory kept in the bench.
module tb_mem_port_arbiter;

    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 3;

    typedef struct {
        logic        we;
        logic [15:0] data;
    } dexp_t;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        if_req, d_req, d_we;
    logic [15:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic        if_valid, d_valid, mem_en, mem_we, stall_if, stall_mem;
    logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata;

    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];
    logic [15:0] if_exp[$];
    dexp_t       d_exp[$];

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          rd_cyc = -1;
    logic [15:0] rd_addr = '0;
    logic [15:0] last_if = '0;
    logic [15:0] last_d = '0;
    int          consec = 0;
    logic        prev_if = 1'b0;

    mem_port_arbiter #(
        .ADDR_W(16), .DATA_W(16), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .Clk(Clk), .Rst(Rst),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic reportFail(input string name);
        tests++;
        fails++;
        $display("[TB] FAIL %s: event count wrong (got none or extra, required exactly one)", name);
    endtask

    task automatic nextCycle();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [15:0] initVal(input int a);
        return 16'(a * 40503 + 7997);
    endfunction

    always @(posedge Clk) cyc++;

    // Memory environment: data read is presented only in the exact cycle MEM_LAT after mem_en
    always @(negedge Clk) begin
        if (mem_en) begin
            rd_cyc  = cyc + MEM_LAT;
            rd_addr = mem_addr;
            if (mem_we) mem[mem_addr] = mem_wdata;
        end
        mem_rdata = (cyc == rd_cyc) ? mem[rd_addr] : 16'($urandom);
    end

    // Monitor: pops the scoreboard on each valid and checks the arbitration guarantees
    always @(negedge Clk) begin
        if (!Rst) begin
            if_exp.delete();
            d_exp.delete();
            last_if = '0;
            last_d  = '0;
            consec  = 0;
        end else begin
            checkOutput("valid_excl", 32'(if_valid & d_valid), 32'd0);
            checkOutput("stall_if", 32'(stall_if), 32'(if_req & ~if_valid));
            checkOutput("stall_mem", 32'(stall_mem), 32'(d_req & ~d_valid));
            if (mem_en) begin
                if (mem_addr >= 16'h1000) begin
                    if (prev_if) begin
                        checkOutput("starve_guard", 32'(consec < STARVE_MAX), 32'd1);
                        consec++;
                    end
                end else begin
                    consec = 0;
                end
            end
            if (if_valid) begin
                if (if_exp.size() == 0) reportFail("if_unexpected_valid");
                else begin
                    last_if = if_exp.pop_front();
                    checkOutput("if_rdata", 32'(if_rdata), 32'(last_if));
                    checkOutput("d_rdata_hold_on_if", 32'(d_rdata), 32'(last_d));
                end
            end
            if (d_valid) begin
                if (d_exp.size() == 0) reportFail("d_unexpected_valid");
                else begin
                    dexp_t e;
                    e = d_exp.pop_front();
                    if (!e.we) last_d = e.data;
                    checkOutput("d_rdata", 32'(d_rdata), 32'(last_d));
                    checkOutput("if_rdata_hold_on_d", 32'(if_rdata), 32'(last_if));
                end
            end
        end
        prev_if = if_req & Rst;
    end

    task automatic applyStimulus(input int n);
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    int gap;
                    logic [15:0] a;
                    bit got;
                    gap = $urandom_range(0, 2);
                    if (gap != 0) begin
                        if_req = 1'b0;
                        repeat (gap) @(posedge Clk);
                        #1;
                    end
                    a = 16'($urandom_range(0, 16'h0FFF));
                    if_addr = a;
                    if_req  = 1'b1;
                    if_exp.push_back(ref_mem[a]);
                    got = 1'b0;
                    for (int t = 0; t < 200 && !got; t++) begin
                        @(negedge Clk);
                        got = if_valid;
                    end
                    if (!got) reportFail("if_timeout");
                    nextCycle();
                end
                if_req = 1'b0;
            end
            begin
                for (int i = 0; i < n; i++) begin
                    int gap;
                    logic [15:0] a;
                    logic [15:0] w;
                    logic we;
                    bit got;
                    gap = $urandom_range(0, 3);
                    if (gap != 0) begin
                        d_req = 1'b0;
                        repeat (gap) @(posedge Clk);
                        #1;
                    end
                    a  = 16'h1000 | 16'($urandom_range(0, 16'h0FFF));
                    w  = 16'($urandom);
                    we = 1'($urandom_range(0, 1));
                    d_addr  = a;
                    d_wdata = w;
                    d_we    = we;
                    d_req   = 1'b1;
                    if (we) begin
                        ref_mem[a] = w;
                        d_exp.push_back('{we: 1'b1, data: 16'h0000});
                    end else begin
                        d_exp.push_back('{we: 1'b0, data: ref_mem[a]});
                    end
                    got = 1'b0;
                    for (int t = 0; t < 200 && !got; t++) begin
                        @(negedge Clk);
                        got = d_valid;
                    end
                    if (!got) reportFail("d_timeout");
                    nextCycle();
                end
                d_req = 1'b0;
            end
        join
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          nv;
        int          first;
        int          second;
        int          g;
        logic [7:0]  seq;
        logic [7:0]  exp_seq;
        logic [15:0] v;

        Rst = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        for (int a = 0; a < 65536; a++) begin
            mem[16'(a)]     = initVal(a);
            ref_mem[16'(a)] = initVal(a);
        end
        mem[16'h0010]     = 16'hA5C3;
        ref_mem[16'h0010] = 16'hA5C3;

        repeat (2) @(negedge Clk);
        checkOutput("rst_mem_en", 32'(mem_en), 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        checkOutput("rst_if_valid", 32'(if_valid), 32'd0);
        checkOutput("rst_d_valid", 32'(d_valid), 32'd0);
        checkOutput("rst_if_rdata", 32'(if_rdata), 32'd0);
        checkOutput("rst_d_rdata", 32'(d_rdata), 32'd0);
        nextCycle();
        Rst = 1'b1;
        nextCycle();

        // Fetch alone at 0x0010
        if_addr = 16'h0010;
        if_req  = 1'b1;
        if_exp.push_back(ref_mem[16'h0010]);
        for (int k = 0; k < 5; k++) begin
            @(negedge Clk);
            checkOutput("fetch_mem_en", 32'(mem_en), 32'(k == 1));
            checkOutput("fetch_valid", 32'(if_valid), 32'(k == 4));
            checkOutput("fetch_stall", 32'(stall_if), 32'(k < 4));
            if (k == 1) checkOutput("fetch_addr", 32'(mem_addr), 32'h0010);
            if (k == 4) checkOutput("fetch_rdata", 32'(if_rdata), 32'hA5C3);
        end
        nextCycle();
        if_req = 1'b0;
        nextCycle();

        // Data write 0x1234 to 0x0200
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0200; d_wdata = 16'h1234;
        ref_mem[16'h0200] = 16'h1234;
        d_exp.push_back('{we: 1'b1, data: 16'h0000});
        for (int k = 0; k < 5; k++) begin
            @(negedge Clk);
            checkOutput("wr_mem_en", 32'(mem_en), 32'(k == 1));
            checkOutput("wr_mem_we", 32'(mem_we), 32'(k == 1));
            checkOutput("wr_d_valid", 32'(d_valid), 32'(k == 4));
            if (k == 1) begin
                checkOutput("wr_mem_addr", 32'(mem_addr), 32'h0200);
                checkOutput("wr_mem_wdata", 32'(mem_wdata), 32'h1234);
            end
            if (k == 4) checkOutput("wr_d_rdata_unchanged", 32'(d_rdata), 32'd0);
        end
        nextCycle();
        d_req = 1'b0; d_we = 1'b0;
        nextCycle();
        checkOutput("wr_mem_content", 32'(mem[16'h0200]), 32'h1234);

        // Read at 0x0300, inputs change and req drops during ISSUE
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0300;
        v = ref_mem[16'h0300];
        d_exp.push_back('{we: 1'b0, data: v});
        nextCycle();
        d_addr = 16'h0400; d_req = 1'b0; d_wdata = 16'hFFFF;
        nv = 0;
        for (int k = 1; k < 10; k++) begin
            @(negedge Clk);
            if (k <= 3) checkOutput("chg_mem_addr", 32'(mem_addr), 32'h0300);
            if (k == 4) begin
                checkOutput("chg_d_valid", 32'(d_valid), 32'd1);
                checkOutput("chg_d_rdata", 32'(d_rdata), 32'(v));
            end
            nv += int'(d_valid);
        end
        checkOutput("chg_single_valid", 32'(nv), 32'd1);
        nextCycle();

        // Back-to-back fetches with if_req held
        if_addr = 16'h0040;
        if_req  = 1'b1;
        if_exp.push_back(ref_mem[16'h0040]);
        if_exp.push_back(ref_mem[16'h0040]);
        first = -1; second = -1; nv = 0;
        for (int k = 0; k < 30 && nv < 2; k++) begin
            @(negedge Clk);
            if (mem_en) begin
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
            nv += int'(if_valid);
        end
        nextCycle();
        if_req = 1'b0;
        checkOutput("b2b_valids", 32'(nv), 32'd2);
        checkOutput("b2b_spacing", 32'(second - first), 32'(MEM_LAT + 3));
        nextCycle();

        // Both ports held: data wins STARVE_MAX times, then fetch, twice over
        if_addr = 16'h0020; d_addr = 16'h1100; d_we = 1'b0;
        if_req = 1'b1; d_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_seq[i] = ((i % (STARVE_MAX + 1)) != STARVE_MAX);
            if (exp_seq[i]) d_exp.push_back('{we: 1'b0, data: ref_mem[16'h1100]});
            else if_exp.push_back(ref_mem[16'h0020]);
        end
        seq = '0; g = 0;
        for (int k = 0; k < 120; k++) begin
            @(negedge Clk);
            if (mem_en && g < 8) begin
                seq[3'(g)] = (mem_addr == 16'h1100);
                g++;
            end
            if (g == 8 && if_valid) break;
        end
        nextCycle();
        if_req = 1'b0; d_req = 1'b0;
        checkOutput("starve_grants", 32'(g), 32'd8);
        checkOutput("starve_order", 32'(seq), 32'(exp_seq));
        nextCycle();

        // Reset asserted during WAIT of a data read
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h1200;
        d_exp.push_back('{we: 1'b0, data: ref_mem[16'h1200]});
        nextCycle();
        @(posedge Clk);
        #2;
        Rst = 1'b0;
        d_req = 1'b0;
        #1;
        checkOutput("midrst_mem_en", 32'(mem_en), 32'd0);
        checkOutput("midrst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("midrst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("midrst_d_valid", 32'(d_valid), 32'd0);
        checkOutput("midrst_d_rdata", 32'(d_rdata), 32'd0);
        checkOutput("midrst_if_rdata", 32'(if_rdata), 32'd0);
        nv = 0;
        repeat (3) begin
            @(negedge Clk);
            nv += int'(d_valid);
        end
        nextCycle();
        Rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge Clk);
            checkOutput("post_rst_mem_en", 32'(mem_en), 32'd0);
            nv += int'(d_valid);
        end
        checkOutput("rst_no_dvalid", 32'(nv), 32'd0);
        nextCycle();

        applyStimulus(25);

        repeat (10) @(negedge Clk);
        checkOutput("if_queue_empty", 32'(if_exp.size()), 32'd0);
        checkOutput("d_queue_empty", 32'(d_exp.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
